exe_mdu: RTL and testbench
==========================

// Module: exe_mdu
// PURPOSE
//   Iterative RV32M multiply/divide unit attached to the execute stage. Accepts one
//   MUL/DIV-class op per handshake, computes over XLEN/BITS_PER_CYCLE cycles and
//   returns one result pulse toward write-back. busy_o stalls decode. flush_i (taken
//   branch/exception) cancels the in-flight op.
// PARAMETERS
//   XLEN            32  operand/result width (even, >= 8)
//   BITS_PER_CYCLE  1   multiplier/quotient bits retired per CALC cycle; must divide XLEN (1,2,4,8)
// PORTS
//   clk            in   1     clock
//   reset          in   1     synchronous, active-high reset
//   req_v_i        in   1     request valid
//   req_rdy_o      out  1     unit can accept (IDLE & ~flush_i)
//   op_i           in   3     funct3: 000 MUL 001 MULH 010 MULHSU 011 MULHU 100 DIV 101 DIVU 110 REM 111 REMU
//   rs1_data_i     in   XLEN  operand 1 (dividend / multiplicand)
//   rs2_data_i     in   XLEN  operand 2 (divisor / multiplier)
//   wbk_adr_i      in   5     destination register, returned with result
//   flush_i        in   1     abort current op; no result produced
//   busy_o         out  1     state != IDLE
//   res_v_o        out  1     result valid, single-cycle pulse
//   res_data_o     out  XLEN  result
//   res_wbk_adr_o  out  5     destination register of result
// BEHAVIOUR
//   Reset: state IDLE; res_v_o=0, res_data_o=0, res_wbk_adr_o=0, busy_o=0, req_rdy_o=1.
//   Handshake: accept on edge where req_v_i & req_rdy_o. Op, operands, wbk_adr captured.
//   Requests only accepted in IDLE. No result backpressure: write-back always takes res_v_o.
//   FSM: IDLE -(accept, normal)-> CALC; IDLE -(accept, fast path)-> DONE;
//        CALC -(step counter == N-1)-> DONE; DONE -> IDLE; any state -(flush_i)-> IDLE.
//   N = XLEN/BITS_PER_CYCLE. Accept cycle = 0; CALC cycles 1..N; DONE (res_v_o=1) in
//   cycle N+1. Fast path: DONE in cycle 1. Back-to-back throughput: N+2 cycles/op.
//   Multiply: unsigned shift-add on magnitudes into a 2*XLEN product. rs1 signed for
//     MULH/MULHSU, rs2 signed for MULH only. Product negated at end if operand signs
//     differ. MUL returns product[XLEN-1:0]; MULH/MULHSU/MULHU return product[2XLEN-1:XLEN].
//   Divide: restoring division on magnitudes, BITS_PER_CYCLE quotient bits per cycle.
//     Signed ops: quotient negated if signs differ; remainder takes the dividend's sign.
//   Fast path (no CALC), RISC-V defined values:
//     divisor 0: DIV/DIVU -> all ones; REM/REMU -> rs1.
//     DIV/REM with rs1=1<<(XLEN-1), rs2=all ones: DIV -> rs1; REM -> 0.
//   Result regs (res_data_o, res_wbk_adr_o) load on the edge entering DONE. They hold
//     their value after DONE until the next result; only res_v_o qualifies them.
//   Flush: flush_i in CALC -> IDLE next cycle, no result. flush_i in DONE -> res_v_o
//     forced 0 combinationally that cycle. flush_i with req_v_i in IDLE -> not accepted.
//   Reset wins over flush and accept. Reset mid-CALC -> full reset state next cycle.
//   Step counter width clog2(N)+1. Wraps never: cleared on accept.
// TESTING (XLEN=32 unless stated)
//   MUL 7 x 0xFFFFFFFD, BPC=1 -> res_data 0xFFFFFFEB, res_v_o in cycle 33 only, busy_o 1..33.
//   0xFFFFFFFF x 0xFFFFFFFF: MULHU -> 0xFFFFFFFE; MULH -> 0x00000000; MULHSU -> 0xFFFFFFFF.
//   DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2; wbk_adr echoed.
//   Fast path: DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0; all with res_v_o in cycle 1.
//   flush_i at CALC cycle 10 -> no res_v_o, req_rdy_o=1 next cycle; new MULHU 3 x 5 -> 0 correct.
//   BPC=4: MUL 0x12345678 x 0x10 -> 0x23456780 in cycle 9. Reset mid-CALC -> all outputs 0 next cycle.

Source files
------------

// File: rtl/exe_mdu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : exe_mdu
//  Purpose  : Iterative RV32M multiply/divide unit for the execute stage.
//             Shift-add multiply / restoring divide on operand magnitudes,
//             BITS_PER_CYCLE bits retired per CALC cycle, one result pulse.
//  Revision : 1.0  initial release
// ============================================================================
module exe_mdu #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_v_i,
    output logic            req_rdy_o,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [4:0]      wbk_adr_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            res_v_o,
    output logic [XLEN-1:0] res_data_o,
    output logic [4:0]      res_wbk_adr_o
);

    localparam int                 c_N     = XLEN / BITS_PER_CYCLE;
    localparam int                 c_CNT_W = $clog2(c_N) + 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(c_N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [2:0]           r_op;
    logic [XLEN-1:0]      r_a;      // multiplicand or divisor magnitude
    logic [XLEN-1:0]      r_hi;     // product high half or partial remainder
    logic [XLEN-1:0]      r_lo;     // multiplier/product low half or dividend/quotient
    logic                 r_neg;    // final result needs negation
    logic [4:0]           r_wbk;
    logic [XLEN-1:0]      r_res_data;
    logic [4:0]           r_res_wbk;

    // Request decode: operand signedness, magnitudes and RISC-V special cases
    logic            w_accept;
    logic            w_is_div;
    logic            w_s1_signed;
    logic            w_s2_signed;
    logic            w_neg1;
    logic            w_neg2;
    logic [XLEN-1:0] w_mag1;
    logic [XLEN-1:0] w_mag2;
    logic            w_div0;
    logic            w_ovf;
    logic            w_fast;
    logic [XLEN-1:0] w_fast_res;

    assign w_accept    = (r_state == S_IDLE) & req_v_i & ~flush_i;
    assign w_is_div    = op_i[2];
    assign w_s1_signed = w_is_div ? ~op_i[0] : (op_i[1:0] == 2'b01 || op_i[1:0] == 2'b10);
    assign w_s2_signed = w_is_div ? ~op_i[0] : (op_i[1:0] == 2'b01);
    assign w_neg1      = w_s1_signed & rs1_data_i[XLEN-1];
    assign w_neg2      = w_s2_signed & rs2_data_i[XLEN-1];
    assign w_mag1      = w_neg1 ? -rs1_data_i : rs1_data_i;
    assign w_mag2      = w_neg2 ? -rs2_data_i : rs2_data_i;
    assign w_div0      = (rs2_data_i == '0);
    assign w_ovf       = (rs1_data_i == {1'b1, {(XLEN-1){1'b0}}}) & (&rs2_data_i);
    assign w_fast      = w_is_div & (w_div0 | (~op_i[0] & w_ovf));
    // Divide-by-zero takes priority; otherwise this is signed overflow
    assign w_fast_res  = w_div0 ? (op_i[1] ? rs1_data_i : {XLEN{1'b1}})
                                : (op_i[1] ? {XLEN{1'b0}} : rs1_data_i);

    // One CALC step: BITS_PER_CYCLE shift-add or restoring-divide iterations
    logic [XLEN:0]   w_sum;
    logic [XLEN:0]   w_rem;
    logic [XLEN-1:0] w_hi;
    logic [XLEN-1:0] w_lo;
    always_comb begin
        w_hi  = r_hi;
        w_lo  = r_lo;
        w_sum = '0;
        w_rem = '0;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            if (r_op[2]) begin
                w_rem = {w_hi, w_lo[XLEN-1]};
                w_lo  = {w_lo[XLEN-2:0], 1'b0};
                if (w_rem >= {1'b0, r_a}) begin
                    w_rem   = w_rem - {1'b0, r_a};
                    w_lo[0] = 1'b1;
                end
                w_hi = w_rem[XLEN-1:0];
            end else begin
                w_sum = {1'b0, w_hi} + (w_lo[0] ? {1'b0, r_a} : {(XLEN+1){1'b0}});
                w_lo  = {w_sum[0], w_lo[XLEN-1:1]};
                w_hi  = w_sum[XLEN:1];
            end
        end
    end

    // Sign fix-up and result selection from the final step's outputs
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rmd;
    logic [XLEN-1:0]   w_res;
    always_comb begin
        w_prod = r_neg ? -{w_hi, w_lo} : {w_hi, w_lo};
        w_quo  = r_neg ? -w_lo : w_lo;
        w_rmd  = r_neg ? -w_hi : w_hi;
        w_res  = '0;
        if (r_op[2])
            w_res = r_op[1] ? w_rmd : w_quo;
        else if (r_op[1:0] == 2'b00)
            w_res = w_prod[XLEN-1:0];
        else
            w_res = w_prod[2*XLEN-1:XLEN];
    end

    // Next-state logic; flush always returns to IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = w_fast ? S_DONE : S_CALC;
            S_CALC:  if (flush_i) w_state_nxt = S_IDLE;
                     else if (r_cnt == c_LAST) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State, datapath and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_op       <= '0;
            r_a        <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_neg      <= 1'b0;
            r_wbk      <= '0;
            r_res_data <= '0;
            r_res_wbk  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_op  <= op_i;
                r_wbk <= wbk_adr_i;
                r_cnt <= '0;
                r_hi  <= '0;
                // Remainder follows the dividend sign; everything else the sign product
                r_neg <= (w_is_div & op_i[1]) ? w_neg1 : (w_neg1 ^ w_neg2);
                r_a   <= w_is_div ? w_mag2 : w_mag1;
                r_lo  <= w_is_div ? w_mag1 : w_mag2;
                if (w_fast) begin
                    r_res_data <= w_fast_res;
                    r_res_wbk  <= wbk_adr_i;
                end
            end else if (r_state == S_CALC && !flush_i) begin
                r_hi  <= w_hi;
                r_lo  <= w_lo;
                r_cnt <= r_cnt + c_CNT_W'(1);
                if (r_cnt == c_LAST) begin
                    r_res_data <= w_res;
                    r_res_wbk  <= r_wbk;
                end
            end
        end
    end

    assign req_rdy_o     = (r_state == S_IDLE) & ~flush_i;
    assign busy_o        = (r_state != S_IDLE);
    assign res_v_o       = (r_state == S_DONE) & ~flush_i;
    assign res_data_o    = r_res_data;
    assign res_wbk_adr_o = r_res_wbk;

endmodule
`default_nettype wire

// File: tb/tb_exe_mdu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_exe_mdu
//  Purpose  : Scoreboard bench for exe_mdu (BPC=1 and BPC=4 instances)
//  Revision : 1.0  initial release
// ============================================================================
module tb_exe_mdu;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int acc_cyc = 0;

    logic        a_req_v, a_rdy, a_flush, a_busy, a_res_v;
    logic [2:0]  a_op;
    logic [31:0] a_rs1, a_rs2, a_res_d;
    logic [4:0]  a_wbk, a_res_w;
    logic        b_req_v, b_rdy, b_flush, b_busy, b_res_v;
    logic [2:0]  b_op;
    logic [31:0] b_rs1, b_rs2, b_res_d;
    logic [4:0]  b_wbk, b_res_w;

    exe_mdu #(.XLEN(32), .BITS_PER_CYCLE(1)) u_dut_a (
        .clk(clk), .reset(reset), .req_v_i(a_req_v), .req_rdy_o(a_rdy), .op_i(a_op),
        .rs1_data_i(a_rs1), .rs2_data_i(a_rs2), .wbk_adr_i(a_wbk), .flush_i(a_flush),
        .busy_o(a_busy), .res_v_o(a_res_v), .res_data_o(a_res_d), .res_wbk_adr_o(a_res_w));

    exe_mdu #(.XLEN(32), .BITS_PER_CYCLE(4)) u_dut_b (
        .clk(clk), .reset(reset), .req_v_i(b_req_v), .req_rdy_o(b_rdy), .op_i(b_op),
        .rs1_data_i(b_rs1), .rs2_data_i(b_rs2), .wbk_adr_i(b_wbk), .flush_i(b_flush),
        .busy_o(b_busy), .res_v_o(b_res_v), .res_data_o(b_res_d), .res_wbk_adr_o(b_res_w));

    typedef struct {
        logic [31:0] d;
        logic [4:0]  w;
        int          c;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // RISC-V M-extension semantics with 64-bit integer arithmetic
    function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        longint    sx, sy, ux, uy;
        logic [63:0] p;
        int        ix, iy;
        logic      ovf;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        ux  = longint'({32'h0, x});
        uy  = longint'({32'h0, y});
        ix  = $signed(x);
        iy  = $signed(y);
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = ux * uy; return p[31:0]; end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * uy; return p[63:32]; end
            3'd3: begin p = ux * uy; return p[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (ovf) return x;
                return ix / iy;
            end
            3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: begin
                if (y == 0) return x;
                if (ovf) return 32'h0;
                return ix % iy;
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic bit is_fast(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        return op[2] && ((y == 0) || (!op[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
    endfunction

    function automatic logic [31:0] pick_opnd();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Monitors: pop one expectation per result pulse
    always @(negedge clk) begin
        if (!reset && a_res_v) begin
            if (q_a.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL A_unexpected_result: got data %h wbk %0d expected no result (cycle %0d)", a_res_d, a_res_w, cyc);
            end else begin
                ea = q_a.pop_front();
                chk("A_data", a_res_d, ea.d);
                chk("A_wbk", 32'(a_res_w), 32'(ea.w));
                chk("A_cycle", 32'(cyc), 32'(ea.c));
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && b_res_v) begin
            if (q_b.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL B_unexpected_result: got data %h wbk %0d expected no result (cycle %0d)", b_res_d, b_res_w, cyc);
            end else begin
                eb = q_b.pop_front();
                chk("B_data", b_res_d, eb.d);
                chk("B_wbk", 32'(b_res_w), 32'(eb.w));
                chk("B_cycle", 32'(cyc), 32'(eb.c));
            end
        end
    end

    // Present one request when the unit is ready; optionally record the expectation
    task automatic issue(input bit dut_b, input logic [2:0] op, input logic [31:0] x,
                         input logic [31:0] y, input logic [4:0] w, input bit push);
        int   t;
        exp_t e;
        t = 0;
        @(negedge clk);
        while (!(dut_b ? b_rdy : a_rdy) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) begin
            n_cmp++; n_bad++;
            $display("FAIL issue_timeout: got req_rdy 0 expected 1 within 300 cycles (cycle %0d)", cyc);
            return;
        end
        acc_cyc = cyc;
        e.d = ref_res(op, x, y);
        e.w = w;
        e.c = cyc + (is_fast(op, x, y) ? 1 : (dut_b ? 9 : 33));
        if (dut_b) begin
            b_req_v = 1'b1; b_op = op; b_rs1 = x; b_rs2 = y; b_wbk = w;
            if (push) q_b.push_back(e);
        end else begin
            a_req_v = 1'b1; a_op = op; a_rs1 = x; a_rs2 = y; a_wbk = w;
            if (push) q_a.push_back(e);
        end
        @(posedge clk);
        #1;
        a_req_v = 1'b0;
        b_req_v = 1'b0;
    endtask

    task automatic wait_neg(input int target);
        @(negedge clk);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (t >= 400) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: got %0d/%0d pending expected 0", q_a.size(), q_b.size());
        end
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        a_req_v = 0; a_op = 0; a_rs1 = 0; a_rs2 = 0; a_wbk = 0; a_flush = 0;
        b_req_v = 0; b_op = 0; b_rs1 = 0; b_rs2 = 0; b_wbk = 0; b_flush = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_A_res_v", 32'(a_res_v), 0);
        chk("rst_A_data", a_res_d, 0);
        chk("rst_A_wbk", 32'(a_res_w), 0);
        chk("rst_A_busy", 32'(a_busy), 0);
        chk("rst_A_rdy", 32'(a_rdy), 1);
        chk("rst_B_rdy", 32'(b_rdy), 1);
        chk("rst_B_busy", 32'(b_busy), 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // MUL with busy window check
        issue(0, 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd3, 1);
        for (int k = 1; k <= 34; k++) begin
            wait_neg(acc_cyc + k);
            chk($sformatf("A_busy_c%0d", k), 32'(a_busy), (k <= 33) ? 32'd1 : 32'd0);
        end

        // High-half multiplies of all-ones operands
        issue(0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 1);
        issue(0, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 1);
        issue(0, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 1);

        // Divides and remainders
        issue(0, 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd7, 1);
        issue(0, 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd8, 1);
        issue(0, 3'd5, 32'd100, 32'd7, 5'd9, 1);
        issue(0, 3'd7, 32'd100, 32'd7, 5'd10, 1);

        // Fast path cases
        issue(0, 3'd4, 32'd5, 32'd0, 5'd11, 1);
        issue(0, 3'd6, 32'd5, 32'd0, 5'd12, 1);
        issue(0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1);
        issue(0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 1);
        wait_drain();

        // Flush in CALC cycle 10, then a fresh op
        issue(0, 3'd0, 32'd123, 32'd456, 5'd15, 0);
        wait_neg(acc_cyc + 9);
        @(posedge clk); #1 a_flush = 1'b1;
        @(posedge clk); #1 a_flush = 1'b0;
        @(negedge clk);
        chk("flush_calc_rdy", 32'(a_rdy), 1);
        chk("flush_calc_busy", 32'(a_busy), 0);
        issue(0, 3'd3, 32'd3, 32'd5, 5'd16, 1);
        wait_drain();

        // Flush in DONE: no pulse, result registers still loaded
        issue(0, 3'd0, 32'd9, 32'd9, 5'd17, 0);
        wait_neg(acc_cyc + 32);
        @(posedge clk); #1 a_flush = 1'b1;
        @(negedge clk);
        chk("flush_done_res_v", 32'(a_res_v), 0);
        chk("flush_done_data", a_res_d, 32'd81);
        chk("flush_done_wbk", 32'(a_res_w), 32'd17);
        @(posedge clk); #1 a_flush = 1'b0;
        @(negedge clk);
        chk("flush_done_busy", 32'(a_busy), 0);

        // Flush together with a request in IDLE: not accepted
        a_req_v = 1'b1; a_op = 3'd0; a_rs1 = 32'd2; a_rs2 = 32'd2; a_flush = 1'b1;
        #1;
        chk("flush_idle_rdy", 32'(a_rdy), 0);
        @(posedge clk); #1 a_req_v = 1'b0; a_flush = 1'b0;
        @(negedge clk);
        chk("flush_idle_busy", 32'(a_busy), 0);

        // Randomized back-to-back traffic on the BPC=1 unit
        for (int i = 0; i < 60; i++)
            issue(0, 3'($urandom_range(0, 7)), pick_opnd(), pick_opnd(), 5'($urandom_range(0, 31)), 1);
        wait_drain();

        // BPC=4 unit: directed then randomized
        issue(1, 3'd0, 32'h1234_5678, 32'h0000_0010, 5'd21, 1);
        for (int i = 0; i < 30; i++)
            issue(1, 3'($urandom_range(0, 7)), pick_opnd(), pick_opnd(), 5'($urandom_range(0, 31)), 1);
        wait_drain();

        // Reset mid-CALC
        issue(0, 3'd0, 32'hDEAD_BEEF, 32'h0000_1235, 5'd22, 1);
        issue(0, 3'd5, 32'hDEAD_BEEF, 32'd3, 5'd23, 0);
        wait_neg(acc_cyc + 5);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_res_v", 32'(a_res_v), 0);
        chk("midrst_data", a_res_d, 0);
        chk("midrst_wbk", 32'(a_res_w), 0);
        chk("midrst_busy", 32'(a_busy), 0);
        chk("midrst_rdy", 32'(a_rdy), 1);
        @(posedge clk); #1 reset = 1'b0;
        repeat (40) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
